// File: rtl/bool_sweep_pkg.sv
// Shared types and helpers for the exhaustive boolean sweep checker.
package bool_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic logic [7:0] bin2gray(input logic [7:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bool_sweep_checker_vec_seq_gen.sv
// Hold counter and vector index for the sweep; GRAY_ORDER_EN selects Gray-coded vector output.
module vec_seq_gen
  import bool_sweep_pkg::*;
#(
  parameter int unsigned N_IN        = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            advance,
  output logic [N_IN-1:0] vec,
  output logic            sample_en,
  output logic            last
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? clog2(HOLD_CYCLES) : 1;

  logic [CW-1:0]   hold_cnt;
  logic [N_IN-1:0] idx;
  logic            hold_end;

  assign hold_end  = (hold_cnt == CW'(HOLD_CYCLES - 1));
  assign sample_en = advance && hold_end;
  assign last      = (idx == '1);

  // Index returns to 0 after the terminal vector so the output idles at vector 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hold_cnt <= '0;
      idx      <= '0;
    end else if (advance) begin
      if (hold_end) begin
        hold_cnt <= '0;
        idx      <= last ? '0 : idx + N_IN'(1);
      end else begin
        hold_cnt <= hold_cnt + CW'(1);
      end
    end
  end

`ifdef GRAY_ORDER_EN
  assign vec = N_IN'(bin2gray(8'(idx)));
`else
  assign vec = idx;
`endif

endmodule

// File: rtl/bool_sweep_checker.sv
// Exhaustive sweep checker for an N_IN-input combinational block; FSM, compare and error capture.
// Vector order is binary by default, reflected Gray when GRAY_ORDER_EN is defined.
module bool_sweep_checker
  import bool_sweep_pkg::*;
#(
  parameter int unsigned              N_IN        = 3,
  parameter int unsigned              HOLD_CYCLES = 4,
  parameter logic [(2**N_IN)-1:0]     TRUTH_TABLE = 8'hE8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            err_valid,
  output logic [N_IN-1:0] first_err_vec
);

  state_t          state, state_nxt;
  logic            start_acc;
  logic            advance;
  logic            sample_en;
  logic            last;
  logic [N_IN-1:0] vec;
  logic            mismatch;
  logic [N_IN:0]   err_cnt_nxt;

  vec_seq_gen #(
    .N_IN        (N_IN),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_acc),
    .advance   (advance),
    .vec       (vec),
    .sample_en (sample_en),
    .last      (last)
  );

  assign vec_out     = vec;
  assign advance     = (state == DRIVE);
  assign busy        = (state == DRIVE);
  assign done        = (state == DONE);
  assign mismatch    = sample_en && (dut_in != TRUTH_TABLE[vec]);
  assign err_cnt_nxt = err_cnt + (N_IN+1)'(mismatch);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = DRIVE;
          start_acc = 1'b1;
        end
      end
      DRIVE: begin
        if (sample_en && last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt       <= '0;
      err_valid     <= 1'b0;
      first_err_vec <= '0;
      pass          <= 1'b0;
    end else if (start_acc) begin
      err_cnt   <= '0;
      err_valid <= 1'b0;
      pass      <= 1'b0;
    end else if (sample_en) begin
      err_cnt <= err_cnt_nxt;
      if (mismatch && !err_valid) begin
        first_err_vec <= vec;
        err_valid     <= 1'b1;
      end
      if (last) begin
        pass <= (err_cnt_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_bool_sweep_checker.sv
// Directed bench for bool_sweep_checker (N_IN=3, HOLD_CYCLES=4, majority truth table).
module tb_bool_sweep_checker;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] vec_out;
  logic       dut_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic       err_valid;
  logic [2:0] first_err_vec;

  int mode;
  int n_total;
  int n_pass;
  int n_fail;

  bool_sweep_checker #(
    .N_IN        (3),
    .HOLD_CYCLES (HOLD),
    .TRUTH_TABLE (8'hE8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .vec_out       (vec_out),
    .dut_in        (dut_in),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .err_valid     (err_valid),
    .first_err_vec (first_err_vec)
  );

  // Device under observation: 0 = majority, 1 = stuck at 0, 2 = AND3
  always_comb begin
    case (mode)
      0:       dut_in = (vec_out[2] & vec_out[1]) | (vec_out[2] & vec_out[0]) | (vec_out[1] & vec_out[0]);
      1:       dut_in = 1'b0;
      default: dut_in = &vec_out;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_vec(input int i);
    logic [2:0] b;
    b = 3'(i);
`ifdef GRAY_ORDER_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic check_reset(input string pfx);
    chk({pfx, "_vec"},   32'(vec_out),       0);
    chk({pfx, "_busy"},  32'(busy),          0);
    chk({pfx, "_done"},  32'(done),          0);
    chk({pfx, "_pass"},  32'(pass),          0);
    chk({pfx, "_cnt"},   32'(err_cnt),       0);
    chk({pfx, "_evld"},  32'(err_valid),     0);
    chk({pfx, "_fev"},   32'(first_err_vec), 0);
  endtask

  // abort_at >= 0 asserts rst during that busy cycle; extra adds start pulses at busy cycles 5 and 31.
  task automatic run_sweep(input int m, input int exp_cnt, input int exp_fev,
                           input bit extra, input int abort_at);
    int cyc;
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy),      1);
    chk("start_done", 32'(done),      0);
    chk("start_cnt",  32'(err_cnt),   0);
    chk("start_evld", 32'(err_valid), 0);
    cyc = 0;
    while (busy && cyc < 100) begin
      if (cyc == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("abort");
        return;
      end
      chk("vec_seq", 32'(vec_out), 32'(exp_vec(cyc / HOLD)));
      start = extra && (cyc == 5 || cyc == 31);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("busy_len", 32'(cyc),       32);
    chk("end_done", 32'(done),      1);
    chk("end_pass", 32'(pass),      (exp_cnt == 0) ? 1 : 0);
    chk("end_cnt",  32'(err_cnt),   32'(exp_cnt));
    chk("end_evld", 32'(err_valid), (exp_cnt == 0) ? 1'b0 : 1'b1);
    chk("end_vec",  32'(vec_out),   0);
    if (exp_cnt != 0) chk("end_fev", 32'(first_err_vec), 32'(exp_fev));
    if (extra) begin
      tick();
      chk("extra_busy", 32'(busy), 0);
      chk("extra_done", 32'(done), 1);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    mode    = 0;
    rst     = 1'b1;
    start   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset("reset");

    run_sweep(0, 0, 0, 1'b0, -1);   // correct majority DUT
    run_sweep(1, 4, 3, 1'b0, -1);   // stuck at 0
    run_sweep(0, 0, 0, 1'b0, -1);   // restart from DONE after a failing sweep
    run_sweep(2, 3, 3, 1'b0, -1);   // AND3
    run_sweep(0, 0, 0, 1'b0, 10);   // reset mid-sweep
    run_sweep(1, 4, 3, 1'b0, -1);   // fresh sweep after reset
    run_sweep(0, 0, 0, 1'b1, -1);   // extra start pulses ignored

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
